// File: rtl/tanh_in_quant_4bit.sv
// Two-stage shift/saturate quantiser feeding a 4-bit tanh lookup; valid/ready on both sides.
// Optional build macro TANH_QUANT_ROUND_EN: round half up before the shift (default: truncate).
module tanh_in_quant_4bit #(
  parameter int IN_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [3:0]       shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       Out1,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic signed [IN_W:0] CODE_MAX = (IN_W+1)'(7);
  localparam logic signed [IN_W:0] CODE_MIN = -(IN_W+1)'(8);

  logic                   s1_valid;
  logic signed [IN_W:0]   s1_data;
  logic                   s2_valid;
  logic [3:0]             s2_code;
  logic                   s2_clip;

  logic                   s2_take;
  logic                   deliver;
  logic signed [IN_W:0]   ext;
  logic signed [IN_W:0]   s1_next;
  logic [3:0]             sat_code;
  logic                   sat_clip;

  // S2 can load when empty or when its current code leaves this cycle.
  assign s2_take   = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s2_take;
  assign deliver   = s2_valid & out_ready;
  assign out_valid = s2_valid;
  assign Out1      = s2_code;

  // One guard bit keeps the rounding increment from overflowing at the positive limit.
  always_comb begin
    ext = {in_data[IN_W-1], in_data};
`ifdef TANH_QUANT_ROUND_EN
    if (shift != 4'd0)
      ext = ext + ((IN_W+1)'(1) << (shift - 4'd1));
`endif
    s1_next = ext >>> shift;
  end

  always_comb begin
    sat_code = s1_data[3:0];
    sat_clip = 1'b0;
    if (s1_data > CODE_MAX) begin
      sat_code = 4'b0111;
      sat_clip = 1'b1;
    end else if (s1_data < CODE_MIN) begin
      sat_code = 4'b1000;
      sat_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_code  <= '0;
      s2_clip  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid)
          s1_data <= s1_next;
      end
      if (s2_take) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_code <= sat_code;
          s2_clip <= sat_clip;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sat_clr)
      sat_cnt <= '0;
    else if (deliver && s2_clip && (sat_cnt != '1))
      sat_cnt <= sat_cnt + 1'b1;
  end

endmodule
